fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-side responder to the CPU controller. Holds program memory, the
//  program counter (PC) and the instruction register (IR). Acts on the
//  controller strobes LoadIR/IncPC/SelPC/LoadPC and returns Opcode to the
//  controller and the immediate field to the ACC/PC muxes.
//  Also has a program-load write port so the bench or top level can fill memory.
// PARAMETERS
//  PC_W    8  PC/address width; memory depth = 2**PC_W words
//  INSTR_W 8  instruction word width; [INSTR_W-1 -: 4] = opcode, [INSTR_W-5:0] = imm
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        synchronous, active-low reset
//  LoadIR      in   1        latch mem[pc] into IR
//  IncPC       in   1        pc <= pc+1
//  LoadPC      in   1        load PC from the source chosen by SelPC
//  SelPC       in   1        0: zero-extended imm from IR; 1: ext_addr
//  ext_addr    in   PC_W     external jump target (e.g. from ACC)
//  prog_we     in   1        program memory write enable
//  prog_addr   in   PC_W     program write address
//  prog_data   in   INSTR_W  program write data
//  Opcode      out  4        IR[INSTR_W-1 -: 4]
//  imm         out  INSTR_W-4  IR[INSTR_W-5:0]
//  pc          out  PC_W     current PC
//  ir_valid    out  1        IR has been loaded at least once since reset
//  pc_wrapped  out  1        sticky: PC wrapped from all-ones to 0
// BEHAVIOUR
//  - All state updates on posedge clk. When reset==0 at an edge: pc=0, IR=0
//    (Opcode=0, imm=0), ir_valid=0, pc_wrapped=0. Memory contents are not
//    reset. prog_we is ignored while reset==0.
//  - Memory: synchronous write on prog_we, combinational read at pc.
//  - IR: on LoadIR, IR <= mem[pc]. pc is the value before this edge.
//    ir_valid <= 1. Without LoadIR, IR holds.
//  - Read/write collision: prog_we to address pc at the same edge as LoadIR.
//    IR gets the OLD word. The new word is visible from the next cycle.
//  - PC update priority:
//      LoadPC > IncPC > hold.
//      LoadPC: pc <= SelPC ? ext_addr : zero-extended imm of the current IR
//      (the pre-edge value, even if LoadIR is also high).
//  - IncPC: pc <= pc+1, modulo 2**PC_W. Incrementing from all-ones sets
//    pc_wrapped, which stays set until reset. LoadPC never sets pc_wrapped.
//  - Controller fetch stage (LoadIR=1, IncPC=1 together): IR gets mem[old pc]
//    and pc advances. Latency from strobe to Opcode/pc outputs is 1 cycle.
//  - Outputs are pure register outputs, with no combinational path from inputs.
//  - Internal control FSM: RESET -> IDLE (IR invalid) -> LOADED (ir_valid=1).
//    A reset taken in any state returns to RESET regardless of other strobes
//    that cycle.
// TESTING
//  1. Hold reset low 2 cycles with all strobes high -> pc=0, Opcode=0, imm=0,
//     ir_valid=0, pc_wrapped=0.
//  2. Write mem[0]=8'h4A, mem[1]=8'h23, then LoadIR+IncPC twice ->
//     Opcode=4/imm=A, pc=1; then Opcode=2/imm=3, pc=2.
//  3. IR=8'h9C; LoadPC=1, SelPC=0, IncPC=1 -> pc=8'h0C (LoadPC wins);
//     SelPC=1, ext_addr=8'hF0 -> pc=8'hF0.
//  4. pc=8'hFF, IncPC -> pc=0, pc_wrapped=1; then LoadPC to 5 -> pc_wrapped
//     stays 1.
//  5. mem[3]=8'h11, pc=3; prog_we to addr 3 with 8'h77 at the same edge as
//     LoadIR -> IR=8'h11; a second LoadIR (pc held) -> IR=8'h77.
//  6. Reset asserted mid-run with LoadIR/IncPC high -> pc=0, ir_valid=0 next
//     cycle; memory still holds earlier data.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-side datapath for the CPU: program memory, PC and IR, driven by
// the controller's LoadIR/IncPC/LoadPC/SelPC strobes.
module fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               LoadIR,
  input  logic               IncPC,
  input  logic               LoadPC,
  input  logic               SelPC,
  input  logic [PC_W-1:0]    ext_addr,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [3:0]         Opcode,
  output logic [INSTR_W-5:0] imm,
  output logic [PC_W-1:0]    pc,
  output logic               ir_valid,
  output logic               pc_wrapped,
  output logic [1:0]         dbg_state
);

  localparam int DEPTH = 1 << PC_W;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOADED = 2'd2
  } state_e;

  state_e             state;
  state_e             state_next;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PC_W-1:0]    imm_ext;

  // Strobes are single-cycle commands with no handshake: each one acts at the
  // edge where it is sampled high, and LoadPC overrides IncPC.

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_RESET;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  state_next = LoadIR ? ST_LOADED : ST_IDLE;
      ST_IDLE:   if (LoadIR) state_next = ST_LOADED;
      ST_LOADED: state_next = ST_LOADED;
      default:   state_next = ST_RESET;
    endcase
  end

  assign ir_valid  = (state == ST_LOADED);
  assign dbg_state = state;

  // Program port is locked out during reset; memory itself is never cleared.
  always_ff @(posedge clk) begin
    if (reset && prog_we) mem[prog_addr] <= prog_data;
  end

  assign imm_ext = PC_W'(ir[INSTR_W-5:0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ir         <= '0;
      pc         <= '0;
      pc_wrapped <= 1'b0;
    end else begin
      // mem read sees the pre-edge contents, so a same-edge write is not seen.
      if (LoadIR) ir <= mem[pc];
      if (LoadPC) begin
        pc <= SelPC ? ext_addr : imm_ext;
      end else if (IncPC) begin
        pc <= pc + PC_W'(1);
        if (&pc) pc_wrapped <= 1'b1;
      end
    end
  end

  assign Opcode = ir[INSTR_W-1 -: 4];
  assign imm    = ir[INSTR_W-5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit, checked against an
// array-based behavioural model of memory, PC and IR.
module tb_fetch_unit;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;
  localparam int DEPTH   = 256;

  logic               clk = 1'b0;
  logic               reset;
  logic               LoadIR, IncPC, LoadPC, SelPC;
  logic [PC_W-1:0]    ext_addr;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [3:0]         Opcode;
  logic [INSTR_W-5:0] imm;
  logic [PC_W-1:0]    pc;
  logic               ir_valid, pc_wrapped;
  logic [1:0]         dbg_state;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .reset(reset), .LoadIR(LoadIR), .IncPC(IncPC),
    .LoadPC(LoadPC), .SelPC(SelPC), .ext_addr(ext_addr),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .Opcode(Opcode), .imm(imm), .pc(pc), .ir_valid(ir_valid),
    .pc_wrapped(pc_wrapped), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem_m [DEPTH];
  int         pc_m = 0;
  int         ir_m = 0;
  bit         valid_m = 0;
  bit         wrapped_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit lir, input bit inc, input bit lpc,
                       input bit sel, input int ext, input bit we, input int wa,
                       input int wd);
    reset     = r;
    LoadIR    = lir;
    IncPC     = inc;
    LoadPC    = lpc;
    SelPC     = sel;
    ext_addr  = ext[7:0];
    prog_we   = we;
    prog_addr = wa[7:0];
    prog_data = wd[7:0];
  endtask

  // One clock: apply the model to the pre-edge inputs, then compare all outputs.
  task automatic cycle();
    bit r, lir, inc, lpc, sel, we;
    int ext, wa, wd, old_pc, old_ir;
    r = reset; lir = LoadIR; inc = IncPC; lpc = LoadPC; sel = SelPC;
    we = prog_we; ext = int'(ext_addr); wa = int'(prog_addr); wd = int'(prog_data);
    @(posedge clk);
    #1;
    if (!r) begin
      pc_m = 0; ir_m = 0; valid_m = 0; wrapped_m = 0;
    end else begin
      old_pc = pc_m;
      old_ir = ir_m;
      if (lir) begin
        ir_m    = int'(mem_m[old_pc]);
        valid_m = 1;
      end
      if (lpc) begin
        pc_m = sel ? ext : old_ir % 16;
      end else if (inc) begin
        if (old_pc == DEPTH - 1) wrapped_m = 1;
        pc_m = (old_pc + 1) % DEPTH;
      end
      if (we) mem_m[wa] = wd[7:0];
    end
    chk("pc", 32'(pc), 32'(pc_m));
    chk("opcode", 32'(Opcode), 32'(ir_m / 16));
    chk("imm", 32'(imm), 32'(ir_m % 16));
    chk("ir_valid", 32'(ir_valid), 32'(valid_m));
    chk("pc_wrapped", 32'(pc_wrapped), 32'(wrapped_m));
  endtask

  task automatic prog_write(input int a, input int d);
    drive(1, 0, 0, 0, 0, 0, 1, a, d);
    cycle();
  endtask

  initial begin
    // Reset with every strobe and the program port active
    drive(0, 1, 1, 1, 1, 8'hAA, 1, 0, 8'h55);
    cycle();
    cycle();
    chk("t1_pc", 32'(pc), 32'h0);
    chk("t1_opcode", 32'(Opcode), 32'h0);
    chk("t1_imm", 32'(imm), 32'h0);
    chk("t1_ir_valid", 32'(ir_valid), 32'h0);
    chk("t1_wrapped", 32'(pc_wrapped), 32'h0);

    for (int a = 0; a < DEPTH; a++) prog_write(a, int'($urandom_range(0, 255)));

    // Fetch two words back to back
    prog_write(0, 8'h4A);
    prog_write(1, 8'h23);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t2_op0", 32'(Opcode), 32'h4);
    chk("t2_imm0", 32'(imm), 32'hA);
    chk("t2_pc0", 32'(pc), 32'h1);
    chk("t2_valid", 32'(ir_valid), 32'h1);
    cycle();
    chk("t2_op1", 32'(Opcode), 32'h2);
    chk("t2_imm1", 32'(imm), 32'h3);
    chk("t2_pc1", 32'(pc), 32'h2);

    // LoadPC beats IncPC; both PC sources
    prog_write(2, 8'h9C);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t3_ir_op", 32'(Opcode), 32'h9);
    drive(1, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    cycle();
    chk("t3_pc_imm", 32'(pc), 32'h0C);
    drive(1, 0, 0, 1, 1, 8'hF0, 0, 0, 0);
    cycle();
    chk("t3_pc_ext", 32'(pc), 32'hF0);
    chk("t3_wrapped", 32'(pc_wrapped), 32'h0);

    // Wrap from all-ones, then LoadPC leaves the flag set
    drive(1, 0, 0, 1, 1, 8'hFF, 0, 0, 0);
    cycle();
    chk("t4_pc_ff", 32'(pc), 32'hFF);
    chk("t4_no_wrap_on_load", 32'(pc_wrapped), 32'h0);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t4_pc_wrap", 32'(pc), 32'h0);
    chk("t4_wrapped", 32'(pc_wrapped), 32'h1);
    drive(1, 0, 0, 1, 1, 8'h05, 0, 0, 0);
    cycle();
    chk("t4_pc5", 32'(pc), 32'h5);
    chk("t4_sticky", 32'(pc_wrapped), 32'h1);

    // Same-edge write and fetch at pc: old word first, new word next
    drive(1, 0, 0, 1, 1, 8'h03, 0, 0, 0);
    cycle();
    prog_write(3, 8'h11);
    drive(1, 1, 0, 0, 0, 0, 1, 3, 8'h77);
    cycle();
    chk("t5_old_op", 32'(Opcode), 32'h1);
    chk("t5_old_imm", 32'(imm), 32'h1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t5_new_op", 32'(Opcode), 32'h7);
    chk("t5_new_imm", 32'(imm), 32'h7);
    chk("t5_pc_held", 32'(pc), 32'h3);

    // Mid-run reset; memory survives
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t6_pc", 32'(pc), 32'h0);
    chk("t6_valid", 32'(ir_valid), 32'h0);
    chk("t6_wrapped", 32'(pc_wrapped), 32'h0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t6_mem_op", 32'(Opcode), 32'h4);
    chk("t6_mem_imm", 32'(imm), 32'hA);
    chk("t6_valid_again", 32'(ir_valid), 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 5) == 0), 1'($urandom),
            int'($urandom_range(0, 255)), 1'($urandom),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
